time_set_sequencer: RTL and testbench

- Digit-editing controller for the watch's SetTime and SetAlarm modes.
- Holds a working HH:MM copy in BCD and walks a digit pointer across it: hours-tens, hours-units, minutes-tens, minutes-units.
- Increments the selected digit on each set press, under 24-hour wrap rules.
- Drives setting_done to the mode FSM, issues a one-cycle load strobe to the normal clock on commit, and owns the stored alarm registers.

---
 rtl/time_set_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_time_set_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/time_set_sequencer.sv
// HH:MM BCD digit editor for SetTime/SetAlarm: walks a digit pointer, increments under 24 h rules,
// commits to set_*/alarm_* with a one-cycle load_time strobe. Define BLINK_EN for the selected-digit blink mask.
module time_set_sequencer #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       setting_mode_en,
  input  logic       alarm_mode_en,
  input  logic       mode,
  input  logic       set,
  input  logic [7:0] cur_hours,
  input  logic [7:0] cur_minutes,
  output logic [1:0] digit_sel,
  output logic [7:0] work_hours,
  output logic [7:0] work_minutes,
  output logic       setting_done,
  output logic       load_time,
  output logic [7:0] set_hours,
  output logic [7:0] set_minutes,
  output logic [7:0] alarm_hours,
  output logic [7:0] alarm_minutes,
  output logic       blink_mask
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EDIT_TIME  = 2'd1,
    EDIT_ALARM = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] digit_sel_q, digit_sel_d;
  logic [7:0] work_h_q, work_h_d, work_m_q, work_m_d;
  logic [7:0] set_h_q, set_h_d, set_m_q, set_m_d;
  logic [7:0] alarm_h_q, alarm_h_d, alarm_m_q, alarm_m_d;
  logic       load_time_q, load_time_d;

  logic       own_en;
  logic [3:0] h_tens, h_units, m_tens, m_units;
  logic [7:0] inc_h, inc_m;

  assign own_en  = (state_q == EDIT_TIME) ? setting_mode_en : alarm_mode_en;
  assign h_tens  = work_h_q[7:4];
  assign h_units = work_h_q[3:0];
  assign m_tens  = work_m_q[7:4];
  assign m_units = work_m_q[3:0];

  // Single-digit increment; no carries. Hours-tens reaching 2 clamps units so 24..29 never appear.
  always_comb begin
    inc_h = work_h_q;
    inc_m = work_m_q;
    case (digit_sel_q)
      2'd0: begin
        if (h_tens >= 4'd2) begin
          inc_h[7:4] = 4'd0;
        end else begin
          inc_h[7:4] = h_tens + 4'd1;
          if ((h_tens == 4'd1) && (h_units > 4'd3)) inc_h[3:0] = 4'd3;
        end
      end
      2'd1: begin
        if (h_units >= ((h_tens == 4'd2) ? 4'd3 : 4'd9)) inc_h[3:0] = 4'd0;
        else                                             inc_h[3:0] = h_units + 4'd1;
      end
      2'd2: begin
        if (m_tens >= 4'd5) inc_m[7:4] = 4'd0;
        else                inc_m[7:4] = m_tens + 4'd1;
      end
      default: begin
        if (m_units >= 4'd9) inc_m[3:0] = 4'd0;
        else                 inc_m[3:0] = m_units + 4'd1;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    digit_sel_d = digit_sel_q;
    work_h_d    = work_h_q;
    work_m_d    = work_m_q;
    set_h_d     = set_h_q;
    set_m_d     = set_m_q;
    alarm_h_d   = alarm_h_q;
    alarm_m_d   = alarm_m_q;
    load_time_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (setting_mode_en) begin
          state_d     = EDIT_TIME;
          work_h_d    = cur_hours;
          work_m_d    = cur_minutes;
          digit_sel_d = 2'd0;
        end else if (alarm_mode_en) begin
          state_d     = EDIT_ALARM;
          work_h_d    = alarm_h_q;
          work_m_d    = alarm_m_q;
          digit_sel_d = 2'd0;
        end
      end
      EDIT_TIME, EDIT_ALARM: begin
        if (!own_en) begin
          state_d     = IDLE;
          digit_sel_d = 2'd0;
        end else if (mode) begin
          if (digit_sel_q != 2'd3) begin
            digit_sel_d = digit_sel_q + 2'd1;
          end else begin
            state_d     = IDLE;
            digit_sel_d = 2'd0;
            if (state_q == EDIT_TIME) begin
              set_h_d     = work_h_q;
              set_m_d     = work_m_q;
              load_time_d = 1'b1;
            end else begin
              alarm_h_d = work_h_q;
              alarm_m_d = work_m_q;
            end
          end
        end else if (set) begin
          work_h_d = inc_h;
          work_m_d = inc_m;
        end
      end
      default: begin
        state_d     = IDLE;
        digit_sel_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      digit_sel_q <= 2'd0;
      work_h_q    <= 8'h00;
      work_m_q    <= 8'h00;
      set_h_q     <= 8'h00;
      set_m_q     <= 8'h00;
      alarm_h_q   <= 8'h00;
      alarm_m_q   <= 8'h00;
      load_time_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_sel_q <= digit_sel_d;
      work_h_q    <= work_h_d;
      work_m_q    <= work_m_d;
      set_h_q     <= set_h_d;
      set_m_q     <= set_m_d;
      alarm_h_q   <= alarm_h_d;
      alarm_m_q   <= alarm_m_d;
      load_time_q <= load_time_d;
    end
  end

`ifdef BLINK_EN
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_mask_q, blink_mask_d;
  logic              inc_fire;

  assign inc_fire = (state_q != IDLE) && own_en && !mode && set;

  // Restart the phase whenever the edited digit moves or changes so it is shown at once.
  always_comb begin
    blink_cnt_d  = blink_cnt_q;
    blink_mask_d = blink_mask_q;
    if ((state_q == IDLE) || (digit_sel_d != digit_sel_q) || inc_fire) begin
      blink_cnt_d  = '0;
      blink_mask_d = 1'b0;
    end else if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_cnt_d  = '0;
      blink_mask_d = ~blink_mask_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q  <= '0;
      blink_mask_q <= 1'b0;
    end else begin
      blink_cnt_q  <= blink_cnt_d;
      blink_mask_q <= blink_mask_d;
    end
  end

  assign blink_mask = blink_mask_q;
`else
  localparam int unsigned unused_blink_div = BLINK_DIV;
  assign blink_mask = 1'b0;
`endif

  assign digit_sel     = digit_sel_q;
  assign work_hours    = work_h_q;
  assign work_minutes  = work_m_q;
  assign setting_done  = (state_q != IDLE) && (digit_sel_q == 2'd3);
  assign load_time     = load_time_q;
  assign set_hours     = set_h_q;
  assign set_minutes   = set_m_q;
  assign alarm_hours   = alarm_h_q;
  assign alarm_minutes = alarm_m_q;

endmodule

// File: tb/tb_time_set_sequencer.sv
// Directed scoreboard bench for time_set_sequencer (default build, BLINK_EN undefined).
module tb_time_set_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       setting_mode_en = 1'b0;
  logic       alarm_mode_en = 1'b0;
  logic       mode = 1'b0;
  logic       set = 1'b0;
  logic [7:0] cur_hours = 8'h00;
  logic [7:0] cur_minutes = 8'h00;
  logic [1:0] digit_sel;
  logic [7:0] work_hours, work_minutes;
  logic       setting_done, load_time, blink_mask;
  logic [7:0] set_hours, set_minutes, alarm_hours, alarm_minutes;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] wh;
    logic [7:0] wm;
    logic [1:0] ds;
    logic       done;
    logic       ld;
  } exp_t;

  exp_t sb[$];

  time_set_sequencer dut (
    .clk(clk), .rst(rst),
    .setting_mode_en(setting_mode_en), .alarm_mode_en(alarm_mode_en),
    .mode(mode), .set(set),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .digit_sel(digit_sel), .work_hours(work_hours), .work_minutes(work_minutes),
    .setting_done(setting_done), .load_time(load_time),
    .set_hours(set_hours), .set_minutes(set_minutes),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp_v);
    n_checks++;
    assert (act === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp_v);
    end
  endtask

  // Queue the expected post-edge view, drive one cycle of inputs, then pop and compare.
  task automatic step(input string tag, input logic sme, input logic ame, input logic md,
                      input logic st, input logic [7:0] eh, input logic [7:0] em,
                      input logic [1:0] eds, input logic edone, input logic eld);
    exp_t e;
    e.wh = eh; e.wm = em; e.ds = eds; e.done = edone; e.ld = eld;
    sb.push_back(e);
    setting_mode_en = sme;
    alarm_mode_en   = ame;
    mode            = md;
    set             = st;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".work"}, {work_hours, work_minutes}, {e.wh, e.wm});
    chk({tag, ".digit"}, {14'd0, digit_sel}, {14'd0, e.ds});
    chk({tag, ".done"}, {15'd0, setting_done}, {15'd0, e.done});
    chk({tag, ".load"}, {15'd0, load_time}, {15'd0, e.ld});
    chk({tag, ".blink"}, {15'd0, blink_mask}, 16'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".work"}, {work_hours, work_minutes}, 16'h0000);
    chk({tag, ".set"}, {set_hours, set_minutes}, 16'h0000);
    chk({tag, ".alarm"}, {alarm_hours, alarm_minutes}, 16'h0000);
    chk({tag, ".ctl"}, {11'd0, digit_sel, setting_done, load_time, blink_mask}, 16'h0000);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    // Enter SetTime from 12:34 and edit to 07:45.
    cur_hours = 8'h12; cur_minutes = 8'h34;
    step("enter_time", 1, 0, 0, 0, 8'h12, 8'h34, 2'd0, 0, 0);
    step("ht_1to2",    1, 0, 0, 1, 8'h22, 8'h34, 2'd0, 0, 0);
    step("ht_2to0",    1, 0, 0, 1, 8'h02, 8'h34, 2'd0, 0, 0);
    step("adv_hu",     1, 0, 1, 0, 8'h02, 8'h34, 2'd1, 0, 0);
    for (int i = 0; i < 5; i++)
      step("hu_inc", 1, 0, 0, 1, {4'h0, 4'(3 + i)}, 8'h34, 2'd1, 0, 0);
    step("adv_mt",     1, 0, 1, 0, 8'h07, 8'h34, 2'd2, 0, 0);
    step("mt_inc",     1, 0, 0, 1, 8'h07, 8'h44, 2'd2, 0, 0);
    step("adv_mu",     1, 0, 1, 0, 8'h07, 8'h44, 2'd3, 1, 0);
    step("mu_inc",     1, 0, 0, 1, 8'h07, 8'h45, 2'd3, 1, 0);
    step("commit_t",   1, 0, 1, 0, 8'h07, 8'h45, 2'd0, 0, 1);
    chk("commit_t.set", {set_hours, set_minutes}, 16'h0745);
    chk("commit_t.alarm", {alarm_hours, alarm_minutes}, 16'h0000);

    // Mode FSM moves straight on to SetAlarm; enter 06:30.
    step("enter_alarm", 0, 1, 0, 0, 8'h00, 8'h00, 2'd0, 0, 0);
    step("a_adv_hu",    0, 1, 1, 0, 8'h00, 8'h00, 2'd1, 0, 0);
    for (int i = 0; i < 6; i++)
      step("a_hu_inc", 0, 1, 0, 1, {4'h0, 4'(1 + i)}, 8'h00, 2'd1, 0, 0);
    step("a_adv_mt",    0, 1, 1, 0, 8'h06, 8'h00, 2'd2, 0, 0);
    for (int i = 0; i < 3; i++)
      step("a_mt_inc", 0, 1, 0, 1, 8'h06, {4'(1 + i), 4'h0}, 2'd2, 0, 0);
    step("a_adv_mu",    0, 1, 1, 0, 8'h06, 8'h30, 2'd3, 1, 0);
    step("commit_a",    0, 1, 1, 0, 8'h06, 8'h30, 2'd0, 0, 0);
    chk("commit_a.alarm", {alarm_hours, alarm_minutes}, 16'h0630);
    chk("commit_a.set", {set_hours, set_minutes}, 16'h0745);

    // Re-entry preloads the stored alarm; aborting keeps it.
    step("idle_hold",   0, 0, 0, 0, 8'h06, 8'h30, 2'd0, 0, 0);
    step("reenter_a",   0, 1, 0, 0, 8'h06, 8'h30, 2'd0, 0, 0);
    step("abort_a",     0, 0, 0, 0, 8'h06, 8'h30, 2'd0, 0, 0);
    chk("abort_a.alarm", {alarm_hours, alarm_minutes}, 16'h0630);

    // 19:00: tens to 2 clamps units to 3; units wrap at 9 when tens < 2.
    cur_hours = 8'h19; cur_minutes = 8'h00;
    step("enter_19",   1, 0, 0, 0, 8'h19, 8'h00, 2'd0, 0, 0);
    step("ht_clamp",   1, 0, 0, 1, 8'h23, 8'h00, 2'd0, 0, 0);
    step("ht_wrap",    1, 0, 0, 1, 8'h03, 8'h00, 2'd0, 0, 0);
    step("adv_hu2",    1, 0, 1, 0, 8'h03, 8'h00, 2'd1, 0, 0);
    for (int i = 0; i < 7; i++)
      step("hu_wrap9", 1, 0, 0, 1, {4'h0, 4'((4 + i) % 10)}, 8'h00, 2'd1, 0, 0);
    step("abort_19",   0, 0, 0, 0, 8'h00, 8'h00, 2'd0, 0, 0);

    // 23:59 boundaries, mode+set collision, abort without strobe.
    cur_hours = 8'h23; cur_minutes = 8'h59;
    step("enter_2359", 1, 0, 0, 0, 8'h23, 8'h59, 2'd0, 0, 0);
    step("adv_hu3",    1, 0, 1, 0, 8'h23, 8'h59, 2'd1, 0, 0);
    step("hu_wrap3",   1, 0, 0, 1, 8'h20, 8'h59, 2'd1, 0, 0);
    step("mode_set",   1, 0, 1, 1, 8'h20, 8'h59, 2'd2, 0, 0);
    step("mt_wrap5",   1, 0, 0, 1, 8'h20, 8'h09, 2'd2, 0, 0);
    step("adv_mu3",    1, 0, 1, 0, 8'h20, 8'h09, 2'd3, 1, 0);
    step("mu_wrap9",   1, 0, 0, 1, 8'h20, 8'h00, 2'd3, 1, 0);
    step("abort_t",    0, 0, 0, 0, 8'h20, 8'h00, 2'd0, 0, 0);
    chk("abort_t.set", {set_hours, set_minutes}, 16'h0745);
    chk("abort_t.alarm", {alarm_hours, alarm_minutes}, 16'h0630);

    // Asynchronous reset in the middle of an edit.
    step("enter_again", 1, 0, 0, 0, 8'h23, 8'h59, 2'd0, 0, 0);
    step("adv_again",   1, 0, 1, 0, 8'h23, 8'h59, 2'd1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("post_rst",    0, 0, 0, 0, 8'h00, 8'h00, 2'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
